router_port_buffer: RTL and testbench
=====================================

// Module: router_port_buffer
// PURPOSE
// - Input-port buffer in front of one router port (N/S/E/W). It absorbs bursts from
//   the upstream producer (GLB, PE, or the neighbouring router's output).
// - Presents an enable-qualified word to the combinational router port. Internally it
//   is a first-word-fall-through FIFO with a valid/ready handshake on both sides.
// - Decouples router_mode changes from upstream traffic: while the port is not being
//   drained, words wait here instead of being lost.
// PARAMETERS
// - DATA_WIDTH  16  payload width; matches the router DATA_WIDTH.
// - DEPTH        4  number of entries; power of 2, >= 2.
// - localparams: AW = $clog2(DEPTH); CW = $clog2(DEPTH+1).
// PORTS
// - clk           in   1           clock; all state updates on the rising edge.
// - reset         in   1           synchronous, active-high reset.
// - in_data_i     in   DATA_WIDTH  upstream word.
// - in_enable_i   in   1           upstream word valid.
// - in_ready_o    out  1           buffer can accept a word this cycle.
// - out_data_o    out  DATA_WIDTH  word to the router port *_data_i.
// - out_enable_o  out  1           word valid, to the router port *_enable_i.
// - out_ready_i   in   1           consumer takes the word this cycle. Tie to 1 when
//                                  the router port is routed for the whole run.
// - count_o       out  CW          current occupancy, 0..DEPTH.
// - overflow_o    out  1           sticky: a word was offered while full.
// BEHAVIOUR
// - Handshake signals:
//   - push = in_enable_i & in_ready_o.
//   - pop = out_enable_o & out_ready_i.
//   - in_ready_o = (count != DEPTH). It is a function of registered state only and
//     never depends on out_ready_i, so there is no combinational in->out ready path.
// - Outputs:
//   - out_enable_o = (count != 0).
//   - out_data_o = mem[rd_ptr] when count != 0, else all zeros.
// - Pointer and count update, per edge (no reset):
//   - push writes mem[wr_ptr] and increments wr_ptr.
//   - pop increments rd_ptr.
//   - Both pointers are AW bits wide and wrap DEPTH-1 -> 0 naturally.
//   - count updates by +push -pop.
//   - Simultaneous push and pop: count is unchanged and both pointers advance.
// - Latency: a word pushed at edge N is on out_data_o with out_enable_o=1 after edge N.
//   Minimum latency is 1 cycle without bypass. Order is strictly FIFO.
// - Full: in_ready_o=0 and no write. If in_enable_i=1 in this cycle, the word is
//   dropped and overflow_o is set from the next edge until reset.
//   - A pop in the same cycle does not admit that word.
// - Empty: out_enable_o=0 and out_data_o=0. out_ready_i is ignored.
// - Holding: out_data_o and out_enable_o stay stable while out_ready_i=0.
// - Reset (including mid-operation):
//   - Clears wr_ptr, rd_ptr, count and overflow_o. mem is not reset.
//   - After the reset edge: out_enable_o=0, out_data_o=0, in_ready_o=1, count_o=0,
//     overflow_o=0. Buffered words are discarded.
//   - push is ignored in any cycle where reset=1.
// CONFIGURATION
// - Macro ROUTER_PORT_BUFFER_BYPASS_EN.
// - Defined: when count==0 && in_enable_i && out_ready_i, the word passes through
//   combinationally.
//   - out_enable_o=1 and out_data_o=in_data_i in the same cycle.
//   - No write occurs and count stays 0.
//   - When count==0 && out_ready_i==0, the word is pushed normally.
//   - When count==0, out_enable_o = in_enable_i.
// - Undefined: no bypass; every word takes the registered path with 1-cycle minimum
//   latency. All other rules are identical.
// TESTING
// - Reset, then idle: out_enable_o=0, out_data_o=0, in_ready_o=1, count_o=0, overflow_o=0.
// - Stream 0x0001..0x0008 with out_ready_i=1 held:
//   - Each word appears 1 cycle after push (0 cycles with BYPASS_EN) in order.
//   - count_o <= 1 throughout.
// - out_ready_i=0, push 0xA0..0xA3 (DEPTH=4):
//   - count_o=4, in_ready_o=0.
//   - 5th word 0xA4 is dropped and overflow_o=1.
//   - Raise out_ready_i: outputs A0, A1, A2, A3, then out_enable_o=0. A4 never appears.
// - Full buffer, push and pop in the same cycle: the pop succeeds, the push is refused,
//   count_o goes 4->3.
//   - On the next cycle a push and pop are both accepted and count_o stays 3.
// - Wrap-around: 3 rounds of push-4 / pop-4 with values 0x10*round+i.
//   - All 12 words come out in order and the pointers wrap cleanly.
// - Reset asserted with 3 words buffered and overflow_o=1:
//   - After the edge, count_o=0, out_enable_o=0, overflow_o=0.
//   - The next pushed word 0x55 is the first word output.

Source files
------------

// File: rtl/router_port_buffer.sv
// First-word-fall-through input buffer for one router port, valid/ready on both sides.
// Optional combinational pass-through when empty: define ROUTER_PORT_BUFFER_BYPASS_EN.
module router_port_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  input  logic                          in_enable_i,
  output logic                          in_ready_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          out_enable_o,
  input  logic                          out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  full;
  logic                  empty;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

`ifdef ROUTER_PORT_BUFFER_BYPASS_EN
  assign bypass       = empty & in_enable_i & out_ready_i;
  assign out_enable_o = empty ? in_enable_i : 1'b1;
  assign out_data_o   = !empty     ? mem[rd_ptr] :
                        in_enable_i ? in_data_i  : '0;
`else
  assign bypass       = 1'b0;
  assign out_enable_o = ~empty;
  assign out_data_o   = empty ? '0 : mem[rd_ready_idx()];
`endif

  // Ready looks only at registered occupancy, so a pop never admits a word to a full buffer.
  assign in_ready_o = ~full;
  assign push       = in_enable_i & ~full & ~bypass & ~reset;
  assign pop        = ~empty & out_ready_i;
  assign count_o    = count;
  assign overflow_o = overflow;

  function automatic logic [AW-1:0] rd_ready_idx();
    return rd_ptr;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (in_enable_i && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data_i;
  end

endmodule

// File: tb/tb_router_port_buffer.sv
// Self-checking bench for router_port_buffer against a queue-based reference model.
module tb_router_port_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef ROUTER_PORT_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] din = '0;
  logic          en = 1'b0;
  logic          rdy = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] out_data_o;
  logic          out_enable_o;
  logic [2:0]    count_o;
  logic          overflow_o;

  router_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_data_i(din), .in_enable_i(en), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_enable_o(out_enable_o), .out_ready_i(rdy),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of buffered words plus the sticky drop flag.
  logic [DW-1:0] q[$];
  bit            ovf_m = 1'b0;
  logic          exp_en, exp_rdy, exp_ovf;
  logic [DW-1:0] exp_data;
  logic [2:0]    exp_cnt;

  task automatic model_out();
    int sz = q.size();
    exp_rdy = (sz != DEPTH);
    exp_cnt = 3'(sz);
    exp_ovf = ovf_m;
    if (sz != 0) begin
      exp_en = 1'b1; exp_data = q[0];
    end else if (BYP && en) begin
      exp_en = 1'b1; exp_data = din;
    end else begin
      exp_en = 1'b0; exp_data = '0;
    end
  endtask

  // Drive one cycle of inputs (held afterwards), clock it, update the model.
  task automatic tick(input bit e, input logic [DW-1:0] d, input bit r);
    int  sz;
    bit  byp, do_push, do_pop;
    en = e; din = d; rdy = r;
    sz      = q.size();
    byp     = BYP && sz == 0 && e && r;
    do_push = e && sz < DEPTH && !byp;
    do_pop  = sz != 0 && r;
    @(posedge clk);
    if (e && sz == DEPTH) ovf_m = 1'b1;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
  endtask

  task automatic do_reset(input bit e);
    reset = 1'b1; en = e; din = 16'hDEAD; rdy = 1'b0;
    @(posedge clk);
    q.delete();
    ovf_m = 1'b0;
    #1;
    reset = 1'b0; en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks += 5;
    if (out_enable_o !== 1'b0) begin errors++; $display("FAIL reset_out_enable: got %b want 0", out_enable_o); end
    if (out_data_o !== 16'h0)  begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data_o); end
    if (in_ready_o !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
    if (count_o !== 3'd0)      begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
    if (overflow_o !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
  endtask

  task automatic test_stream();
    // Before any edge the word is visible only through the bypass.
    en = 1'b1; din = 16'h0001; rdy = 1'b1; #1;
    checks++;
    if (out_enable_o !== BYP) begin errors++; $display("FAIL stream_latency: got %b want %b", out_enable_o, BYP); end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, DW'(i), 1'b1);
      checks += 3;
      if (out_enable_o !== 1'b1) begin errors++; $display("FAIL stream_enable[%0d]: got %b want 1", i, out_enable_o); end
      if (out_data_o !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data_o, DW'(i)); end
      if (count_o > 3'd1)        begin errors++; $display("FAIL stream_count[%0d]: got %0d want <=1", i, count_o); end
    end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (out_enable_o !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", out_enable_o); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 4; i++) tick(1'b1, DW'(16'hA0 + i), 1'b0);
    checks += 2;
    if (count_o !== 3'd4)    begin errors++; $display("FAIL full_count: got %0d want 4", count_o); end
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready_o); end
    tick(1'b1, 16'hA4, 1'b0);
    en = 1'b0; #1;
    checks += 2;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b want 1", overflow_o); end
    if (count_o !== 3'd4)    begin errors++; $display("FAIL full_count_after_drop: got %0d want 4", count_o); end
    for (int k = 0; k < 5; k++) begin
      logic          want_en;
      logic [DW-1:0] want_d;
      want_en = (k < 4);
      want_d  = (k < 4) ? DW'(16'hA0 + k) : '0;
      checks += 2;
      if (out_enable_o !== want_en) begin errors++; $display("FAIL drain_enable[%0d]: got %b want %b", k, out_enable_o, want_en); end
      if (out_data_o !== want_d)    begin errors++; $display("FAIL drain_data[%0d]: got %h want %h", k, out_data_o, want_d); end
      tick(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) tick(1'b1, DW'(16'hB0 + i), 1'b0);
    tick(1'b1, 16'hBE, 1'b1);
    checks++;
    if (count_o !== 3'd3) begin errors++; $display("FAIL fullpp_count: got %0d want 3", count_o); end
    tick(1'b1, 16'hBF, 1'b1);
    checks++;
    if (count_o !== 3'd3) begin errors++; $display("FAIL pp_count: got %0d want 3", count_o); end
    en = 1'b0; #1;
    while (q.size() != 0) begin
      model_out();
      checks++;
      if (out_data_o !== exp_data) begin errors++; $display("FAIL pp_order: got %h want %h", out_data_o, exp_data); end
      tick(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) tick(1'b1, DW'(16'h10 * r + i), 1'b0);
      en = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_data_o !== DW'(16'h10 * r + i)) begin
          errors++; $display("FAIL wrap_data[%0d][%0d]: got %h want %h", r, i, out_data_o, DW'(16'h10 * r + i));
        end
        tick(1'b0, '0, 1'b1);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      tick(1'($urandom_range(0, 99) < 60), DW'($urandom), 1'($urandom_range(0, 99) < 45));
      model_out();
      checks += 5;
      if (out_enable_o !== exp_en) begin errors++; $display("FAIL rand_enable[%0d]: got %b want %b", c, out_enable_o, exp_en); end
      if (out_data_o !== exp_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", c, out_data_o, exp_data); end
      if (in_ready_o !== exp_rdy)  begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready_o, exp_rdy); end
      if (count_o !== exp_cnt)     begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, count_o, exp_cnt); end
      if (overflow_o !== exp_ovf)  begin errors++; $display("FAIL rand_overflow[%0d]: got %b want %b", c, overflow_o, exp_ovf); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, DW'(16'hC0 + i), 1'b0);
    tick(1'b0, '0, 1'b1);
    checks += 2;
    if (count_o !== 3'd3)    begin errors++; $display("FAIL mid_pre_count: got %0d want 3", count_o); end
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL mid_pre_overflow: got %b want 1", overflow_o); end
    do_reset(1'b1);
    checks += 3;
    if (count_o !== 3'd0)      begin errors++; $display("FAIL mid_count: got %0d want 0", count_o); end
    if (out_enable_o !== 1'b0) begin errors++; $display("FAIL mid_enable: got %b want 0", out_enable_o); end
    if (overflow_o !== 1'b0)   begin errors++; $display("FAIL mid_overflow: got %b want 0", overflow_o); end
    tick(1'b1, 16'h0055, 1'b0);
    en = 1'b0; #1;
    checks += 2;
    if (out_enable_o !== 1'b1)  begin errors++; $display("FAIL mid_first_enable: got %b want 1", out_enable_o); end
    if (out_data_o !== 16'h0055) begin errors++; $display("FAIL mid_first_data: got %h want 0055", out_data_o); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_full_overflow();
    test_full_push_pop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
